// File: rtl/led_seq_ctrl.sv
// Purpose : Avalon-MM sequencer that steps a CSR-loaded pattern table out to an LED PIO register.
// Latency : first PIO write the cycle after the start write; steps max(PERIOD,1)+1 cycles apart.
// Backpress: m_waitrequest holds the current write (data stable) and delays only later steps.
module led_seq_ctrl #(
  parameter int          PERIOD_W = 24,
  parameter int          DEPTH    = 8,
  parameter logic [1:0]  PIO_ADDR = 2'b00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [1:0]  m_address,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  output logic        busy
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_WAIT} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    r_len;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_cnt;
  logic [7:0]          r_wdata;
  logic                r_done;
  logic                r_loop;
  logic                r_stop_pend;
  logic [7:0]          r_table [DEPTH];

  logic                w_ctrl_wr;
  logic                w_per_wr;
  logic                w_len_wr;
  logic                w_pat_wr;
  logic                w_start;
  logic                w_stop;
  logic                w_stop_x;
  logic                w_xfer_done;
  logic                w_last;
  logic                w_set_done;
  logic [PERIOD_W-1:0] w_cnt_load;
  logic                w_unused;

  assign w_ctrl_wr   = write && (address == 2'd0);
  assign w_per_wr    = write && (address == 2'd1);
  assign w_len_wr    = write && (address == 2'd2);
  assign w_pat_wr    = write && (address == 2'd3);
  assign w_start     = w_ctrl_wr && writedata[0];
  assign w_stop      = w_ctrl_wr && !writedata[0];
  // A stop that arrives while stalled is remembered until the transfer finishes.
  assign w_stop_x    = w_stop || r_stop_pend;
  assign w_xfer_done = (r_state == S_XFER) && !m_waitrequest;
  assign w_last      = (r_idx == r_len);
  assign w_set_done  = w_xfer_done && w_last && !r_loop;
  // PERIOD of 0 behaves like 1 so a step always spends at least one cycle in WAIT.
  assign w_cnt_load  = (r_period == '0) ? '0 : r_period - PERIOD_W'(1);
  assign w_unused    = ^{writedata[31:12], writedata[11:8], read};

  assign m_address   = PIO_ADDR;
  assign m_writedata = {24'h0, r_wdata};

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_next = S_XFER;
      S_XFER: begin
        if (w_xfer_done) begin
          if (w_stop_x)               w_next = S_IDLE;
          else if (!w_last || r_loop) w_next = S_WAIT;
          else                        w_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (w_stop)              w_next = S_IDLE;
        else if (r_cnt == '0)    w_next = S_XFER;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    m_write = (r_state == S_XFER);
    busy    = (r_state != S_IDLE);
  end

  // Sequencing datapath: index, period counter, latched LED data, status bits
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_idx       <= '0;
      r_cnt       <= '0;
      r_wdata     <= '0;
      r_done      <= 1'b0;
      r_loop      <= 1'b0;
      r_stop_pend <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_start) begin
        r_idx   <= '0;
        r_wdata <= r_table[0];
      end else if (r_state == S_XFER && w_next == S_WAIT) begin
        r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
        r_cnt <= w_cnt_load;
      end else if (r_state == S_WAIT && w_next == S_XFER) begin
        r_wdata <= r_table[r_idx];
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - PERIOD_W'(1);
      end

      if (w_start) r_loop <= writedata[1];

      // Completion beats a simultaneous clear.
      if (w_set_done)
        r_done <= 1'b1;
      else if (w_ctrl_wr && (writedata[2] || (w_start && r_state == S_IDLE)))
        r_done <= 1'b0;

      if (r_state != S_XFER || w_xfer_done) r_stop_pend <= 1'b0;
      else if (w_stop)                      r_stop_pend <= 1'b1;
    end
  end

  // Period and length registers; length is clamped to the table size on write
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_period <= '0;
      r_len    <= '0;
    end else begin
      if (w_per_wr) r_period <= writedata[PERIOD_W-1:0];
      if (w_len_wr) begin
        if (writedata[3:0] >= 4'(DEPTH - 1)) r_len <= IDX_W'(DEPTH - 1);
        else                                 r_len <= writedata[IDX_W-1:0];
      end
    end
  end

  // Pattern table: contents not reset
  always_ff @(posedge clk) begin
    if (w_pat_wr) r_table[writedata[8 +: IDX_W]] <= writedata[7:0];
  end

  // CSR read mux, zero wait states
  always_comb begin
    readdata = '0;
    case (address)
      2'd0: begin
        readdata[24 +: IDX_W] = r_idx;
        readdata[2]           = r_done;
        readdata[1]           = r_loop;
        readdata[0]           = busy;
      end
      2'd1: readdata[PERIOD_W-1:0] = r_period;
      2'd2: readdata[IDX_W-1:0]    = r_len;
      2'd3: readdata[7:0]          = r_table[r_idx];
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: scoreboard of expected PIO writes (data and start spacing).
// Expected writes are queued when a run is started and popped as the master port issues them.
// Stalled writes are checked for stable data; CSR state is checked after each scenario.
module tb_led_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        read;
  logic [31:0] readdata;
  logic        write;
  logic [31:0] writedata;
  logic [1:0]  m_address;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_waitrequest;
  logic        busy;

  led_seq_ctrl #(.PERIOD_W(24), .DEPTH(8), .PIO_ADDR(2'b00)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read), .readdata(readdata),
    .write(write), .writedata(writedata), .m_address(m_address), .m_write(m_write),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dat;
    int         gap;   // cycles since previous write start; 0 = not checked
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          n_starts = 0;
  int          last_start = 0;
  int          cur_len = 0;
  int          last_len = 0;
  bit          in_xfer = 0;
  logic [31:0] held;
  logic [31:0] rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: each new write start is matched against the scoreboard
  always @(negedge clk) begin
    if (m_write) begin
      if (!in_xfer) begin
        in_xfer = 1;
        n_starts++;
        cur_len = 1;
        held = m_writedata;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", m_writedata, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wr_data", m_writedata, {24'h0, e.dat});
          chk("wr_addr", {30'h0, m_address}, 32'h0);
          if (e.gap != 0) chk("wr_gap", cyc - last_start, e.gap);
        end
        last_start = cyc;
      end else begin
        cur_len++;
        chk("stall_stable", m_writedata, held);
      end
      if (!m_waitrequest) begin
        in_xfer = 0;
        last_len = cur_len;
      end
    end else begin
      in_xfer = 0;
    end
  end

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    address = a; writedata = d; write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    #1;
    d = readdata;
    read = 1'b0;
  endtask

  task automatic push(input logic [7:0] dat, input int gap);
    exp_t e;
    e.dat = dat; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    chk(tag, {31'h0, ok}, 32'h1);
  endtask

  task automatic load_walk();
    csr_wr(2'd3, 32'h0000_0001);
    csr_wr(2'd3, 32'h0000_0102);
    csr_wr(2'd3, 32'h0000_0204);
    csr_wr(2'd3, 32'h0000_0308);
  endtask

  initial begin
    reset_n = 1'b0; address = '0; read = 1'b0; write = 1'b0;
    writedata = '0; m_waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    chk("rst_m_write", {31'h0, m_write}, 32'h0);
    chk("rst_m_wdata", m_writedata, 32'h0);
    csr_rd(2'd0, rd); chk("rst_ctrl", rd, 32'h0);
    csr_rd(2'd1, rd); chk("rst_period", rd, 32'h0);
    csr_rd(2'd2, rd); chk("rst_len", rd, 32'h0);

    // One-shot walk
    load_walk();
    csr_wr(2'd2, 32'h0000_000F);
    csr_rd(2'd2, rd); chk("len_clamp", rd, 32'h7);
    csr_wr(2'd2, 32'h3);
    csr_wr(2'd1, 32'h4);
    csr_rd(2'd1, rd); chk("period_rb", rd, 32'h4);
    csr_rd(2'd3, rd); chk("pat_rd_idx0", rd, 32'h01);
    push(8'h01, 0); push(8'h02, 5); push(8'h04, 5); push(8'h08, 5);
    csr_wr(2'd0, 32'h1);
    wait_idle("oneshot_idle");
    csr_rd(2'd0, rd); chk("oneshot_ctrl", rd, 32'h0300_0004);

    // Loop, then stop during WAIT
    push(8'h01, 0); push(8'h02, 5); push(8'h04, 5); push(8'h08, 5); push(8'h01, 5);
    csr_wr(2'd0, 32'h3);
    fork
      wait (n_starts == 9);
      begin repeat (200) @(posedge clk); end
    join_any
    disable fork;
    chk("loop_reached", n_starts, 9);
    csr_wr(2'd0, 32'h0);
    chk("stop_busy", {31'h0, busy}, 32'h0);
    csr_rd(2'd0, rd); chk("stop_ctrl", rd & 32'h0F00_0005, 32'h0100_0000);
    repeat (20) @(posedge clk);

    // Stall on the second transfer
    push(8'h01, 0); push(8'h02, 5); push(8'h04, 8); push(8'h08, 5);
    csr_wr(2'd0, 32'h1);
    fork
      begin
        wait (n_starts == 10);
        @(posedge clk); #1 m_waitrequest = 1'b1;
        wait (n_starts == 11);
        repeat (3) @(posedge clk);
        #1 m_waitrequest = 1'b0;
        @(posedge clk); #1;
        chk("stall_len", last_len, 4);
      end
      begin repeat (300) @(posedge clk); end
    join_any
    disable fork;
    m_waitrequest = 1'b0;
    wait_idle("stall_idle");
    csr_rd(2'd0, rd); chk("stall_ctrl", rd, 32'h0300_0004);

    // PERIOD 0 acts like 1
    csr_wr(2'd1, 32'h0);
    csr_wr(2'd2, 32'h1);
    push(8'h01, 0); push(8'h02, 2);
    csr_wr(2'd0, 32'h1);
    wait_idle("p0_idle");
    csr_rd(2'd0, rd); chk("p0_ctrl", rd, 32'h0100_0004);

    // Stop during a stalled transfer
    csr_wr(2'd1, 32'h4);
    csr_wr(2'd2, 32'h3);
    m_waitrequest = 1'b1;
    push(8'h01, 0);
    csr_wr(2'd0, 32'h3);
    csr_wr(2'd0, 32'h0);
    chk("stopx_held", {31'h0, m_write}, 32'h1);
    repeat (2) @(posedge clk);
    #1 m_waitrequest = 1'b0;
    wait_idle("stopx_idle");
    csr_rd(2'd0, rd); chk("stopx_ctrl", rd & 32'h0000_0005, 32'h0);
    repeat (20) @(posedge clk);

    // Reset mid-transfer, then replay from index 0
    m_waitrequest = 1'b1;
    push(8'h01, 0);
    csr_wr(2'd0, 32'h1);
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    m_waitrequest = 1'b0;
    chk("rst2_m_write", {31'h0, m_write}, 32'h0);
    chk("rst2_busy", {31'h0, busy}, 32'h0);
    csr_rd(2'd0, rd); chk("rst2_ctrl", rd, 32'h0);
    csr_rd(2'd1, rd); chk("rst2_period", rd, 32'h0);
    csr_rd(2'd2, rd); chk("rst2_len", rd, 32'h0);
    load_walk();
    csr_wr(2'd2, 32'h1);
    csr_wr(2'd1, 32'h2);
    push(8'h01, 0); push(8'h02, 3);
    csr_wr(2'd0, 32'h1);
    wait_idle("replay_idle");
    csr_rd(2'd0, rd); chk("replay_ctrl", rd, 32'h0100_0004);

    repeat (10) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- Avalon-MM sequencer that drives the 8-bit LED PIO register through its master port.
- Software loads a pattern table (up to DEPTH entries), a step period and a run mode through the slave CSR port.
- The block then writes each entry to the PIO LED register at PIO_ADDR, one per period, either once or looping.
- Sits between the CPU bus and the LED PIO; the PIO slave connects directly to its master port.

Parameters:
- PERIOD_W, 24: width of the step-period register and the down-counter.
- DEPTH, 8: number of pattern-table entries; power of two, 2..16.
- PIO_ADDR, 2'b00: word address of the LED register in the PIO.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; one clock; reset is synchronous and active-low.
- address  in  2  CSR word address.
- read  in  1  CSR read strobe.
- readdata  out  32  CSR read data; combinational, zero wait states.
- write  in  1  CSR write strobe.
- writedata  in  32  CSR write data.
- m_address  out  2  master address to the PIO.
- m_write  out  1  master write request.
- m_writedata  out  32  master write data.
- m_waitrequest  in  1  slave stall; tie 0 for a zero-wait PIO.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- CSR map:
  - 0 CTRL: W bit0 start/enable, bit1 loop, bit2 clear done. R {idx[27:24], done[2], loop[1], busy[0]}.
  - 1 PERIOD: R/W [PERIOD_W-1:0].
  - 2 LEN: R/W [3:0], holds step count minus 1; values >= DEPTH clamp to DEPTH-1.
  - 3 PAT: W writedata[11:8] = index, writedata[7:0] = entry. R returns the entry at the current idx.
  - Unused readdata bits read 0. Reads have no side effects.
- Reset (reset_n low at clk edge):
  - State IDLE; idx, PERIOD, LEN, loop, done, counter = 0.
  - m_write = 0, m_writedata = 0, m_address = PIO_ADDR, busy = 0.
  - Table contents undefined.
  - Asserting reset during a transfer drops m_write at that edge.
- FSM states: IDLE, XFER, WAIT.
  - IDLE, CTRL write with bit0 = 1: idx <= 0, done <= 0, latch table[0] into m_writedata[7:0] with upper bits 0, go to XFER. The first LED write appears the cycle after the CSR write.
  - XFER: m_write = 1. m_writedata is held stable while m_waitrequest = 1. A transfer completes on the edge where m_write = 1 and m_waitrequest = 0. On completion:
    - idx < LEN: idx++, counter <= max(PERIOD, 1) - 1, go to WAIT.
    - idx == LEN and loop = 1: idx <= 0, load counter, go to WAIT.
    - idx == LEN and loop = 0: done <= 1, go to IDLE.
  - WAIT: counter decrements each cycle. At counter == 0, latch table[idx] and go to XFER. The step-to-step interval is max(PERIOD, 1) + 1 cycles when m_waitrequest = 0.
- CTRL write with bit0 = 0 (stop):
  - In WAIT: go to IDLE next cycle, done not set.
  - In XFER: the current transfer is completed (m_write is never dropped while stalled), then IDLE.
- CTRL bit0 = 1 while busy: updates the loop bit only, no restart. Bit2 clears done; if bit2 and completion coincide, completion wins.
- PAT writes are accepted at any time. An entry is sampled only when entering XFER, so a write to the in-flight entry affects only the next pass.
- PERIOD and LEN changes take effect at the next counter load or wrap check.
- idx width is clog2(DEPTH); wraps only via the loop rule.

Test Plan:
- Reset: load PAT 0..3 = 01,02,04,08; LEN = 3; PERIOD = 4; CTRL = 1 -> four PIO writes of 0x01,0x02,0x04,0x08 at PIO_ADDR, each start 5 cycles apart; then done = 1, busy = 0.
- Same setup with CTRL = 3 (loop) -> after 0x08 the next write is 0x01 after 5 cycles; CTRL = 0 during WAIT -> no further writes, busy falls the next cycle, done = 0.
- Hold m_waitrequest = 1 for 3 cycles on the second transfer -> m_write and m_writedata = 0x02 stay stable for all 4 cycles; only the next step's start is delayed.
- PERIOD = 0, LEN = 1 -> writes 2 cycles apart, identical to PERIOD = 1.
- Stop via CTRL = 0 during a stalled XFER -> transfer completes when m_waitrequest falls, then IDLE with no further writes.
- reset_n low for 1 cycle mid-XFER -> m_write = 0 and all CSR reads = 0 next cycle; a new start replays from idx 0.
